// File: rtl/inst_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: datapath width,
// PC increment and the buffered {pc, inst} entry.
package inst_prefetch_queue_pkg;

    localparam int unsigned BIN_DIG = 32;
    localparam int unsigned XLEN    = BIN_DIG;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } pf_entry_t;

endpackage

// File: rtl/inst_prefetch_queue_pf_fifo.sv
// Synchronous FIFO of prefetched {pc, inst} entries with flush; the head is
// read straight from storage and reads as zero when the FIFO is empty.
module pf_fifo
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  pf_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output logic          head_valid,
    output pf_entry_t     head
);

    pf_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    // Flush wins over both ends; popping an empty FIFO is a no-op
    always_comb begin
        push_en    = push && !flush;
        pop_en     = pop && !flush && (count != '0);
        head_valid = (count != '0);
        head       = head_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage carries no reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

    // Upstream credit accounting must never push into a full FIFO
    always_ff @(posedge clk) begin
        if (!rst && push_en) assert (count < CW'(DEPTH));
    end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential imem fetches, in-order response
// buffering and redirect flush. Define PREFETCH_STATS_EN for drop/starve counters.
module inst_prefetch_queue
    import inst_prefetch_queue_pkg::*;
#(
    parameter int unsigned     DEPTH     = 4,
    parameter int unsigned     MAX_OUTST = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            dec_valid,
    output logic [XLEN-1:0] dec_pc,
    output logic [XLEN-1:0] dec_inst,
`ifdef PREFETCH_STATS_EN
    output logic [15:0]     stat_drop_cnt,
    output logic [15:0]     stat_starve_cnt,
`endif
    input  logic            dec_ready
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] resp_pc;
    logic [OW-1:0]   outst;
    logic [OW-1:0]   drop;
    logic            run;

    logic [OW-1:0]   live_outst;
    logic [OW-1:0]   outst_next;
    logic [CW-1:0]   fifo_count;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            discard;
    pf_entry_t       push_data;
    pf_entry_t       head;

    // Credit check: buffered plus live in-flight responses must fit in the FIFO
    always_comb begin
        live_outst     = outst - drop;
        imem_req_valid = run && !redirect_valid
                         && ((SW'(fifo_count) + SW'(live_outst)) < SW'(DEPTH))
                         && (outst < OW'(MAX_OUTST));
        imem_req_addr  = req_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        outst_next     = outst + OW'(req_fire) - OW'(imem_resp_valid);
        discard        = imem_resp_valid && (redirect_valid || (drop != '0));
        push           = imem_resp_valid && !discard;
        pop            = dec_valid && dec_ready;
        push_data.pc   = resp_pc;
        push_data.inst = imem_resp_data;
    end

    // Redirect restarts both PC streams and marks everything in flight as stale
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_pc  <= RESET_PC;
            resp_pc <= RESET_PC;
            outst   <= '0;
            drop    <= '0;
            run     <= 1'b0;
        end else begin
            run   <= 1'b1;
            outst <= outst_next;
            if (redirect_valid) begin
                req_pc  <= redirect_pc;
                resp_pc <= redirect_pc;
                drop    <= outst_next;
            end else begin
                if (req_fire) req_pc <= req_pc + PC_STEP;
                if (imem_resp_valid) begin
                    if (drop != '0) drop <= drop - OW'(1);
                    else            resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    pf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (fifo_count),
        .head_valid (dec_valid),
        .head       (head)
    );

    assign dec_pc   = head.pc;
    assign dec_inst = head.inst;

`ifdef PREFETCH_STATS_EN
    // Saturating event counters for stale discards and decode starvation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_drop_cnt   <= '0;
            stat_starve_cnt <= '0;
        end else begin
            if (discard && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'd1;
            if (run && !dec_valid && !redirect_valid && (stat_starve_cnt != 16'hFFFF))
                stat_starve_cnt <= stat_starve_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a fixed-latency in-order
// instruction memory model; response data is the bitwise inverse of the address.
module tb_inst_prefetch_queue;

    logic        CLK;
    logic        RST;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_ready;
`ifdef PREFETCH_STATS_EN
    logic [15:0] stat_drop_cnt;
    logic [15:0] stat_starve_cnt;
`endif

    inst_prefetch_queue dut (
        .CLK             (CLK),
        .RST             (RST),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .dec_valid       (dec_valid),
        .dec_pc          (dec_pc),
        .dec_inst        (dec_inst),
`ifdef PREFETCH_STATS_EN
        .stat_drop_cnt   (stat_drop_cnt),
        .stat_starve_cnt (stat_starve_cnt),
`endif
        .dec_ready       (dec_ready)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] fires[$];
    logic [31:0] pops[$];
    int          cyc;
    int          lat;
    logic        mem_ready;
    logic        req_v_seen;
    int          first_fire_cyc;
    int          first_dec_cyc;
    int          inst_bad;
    int          stale;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present memory inputs, settle, log handshakes, advance
    task automatic tick();
        imem_req_ready = mem_ready;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = ~mq[0].addr;
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        req_v_seen = imem_req_valid;
        if (imem_req_valid && imem_req_ready) begin
            fires.push_back(imem_req_addr);
            mq.push_back('{addr: imem_req_addr, due: cyc + lat});
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
        end
        if (dec_valid && first_dec_cyc < 0) first_dec_cyc = cyc;
        if (dec_valid && dec_ready && !redirect_valid) begin
            pops.push_back(dec_pc);
            if (dec_inst !== ~dec_pc) inst_bad++;
        end
        @(negedge CLK);
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset DUT and memory model together; cycle 0 begins at release
    task automatic do_reset();
        RST             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        dec_ready       = 1'b0;
        mem_ready       = 1'b1;
        mq.delete();
        fires.delete();
        pops.delete();
        first_fire_cyc  = -1;
        first_dec_cyc   = -1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        inst_bad = 0;
        lat      = 1;
        RST      = 1'b0;
        #1;

        // Reset values
        do_reset();
        RST = 1'b1;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_inst", dec_inst, 32'h0);

        // Streaming with 1-cycle memory and a free decoder
        do_reset();
        lat = 1; dec_ready = 1'b1;
        ticks(8);
        chk("s_first_fire", 32'(first_fire_cyc), 32'd1);
        chk("s_first_dec", 32'(first_dec_cyc), 32'd3);
        chk("s_fire0", fires[0], 32'h0);
        chk("s_fire1", fires[1], 32'h4);
        chk("s_fire2", fires[2], 32'h8);
        chk("s_npops", 32'(pops.size()), 32'd5);
        chk("s_pop0", pops[0], 32'h0);
        chk("s_pop1", pops[1], 32'h4);
        chk("s_pop4", pops[4], 32'h10);

        // Decoder stalled: credits stop fetch at DEPTH
        do_reset();
        lat = 1; dec_ready = 1'b0;
        ticks(10);
        chk("f_nfires", 32'(fires.size()), 32'd4);
        chk("f_req_valid", 32'(imem_req_valid), 32'd0);
        chk("f_dec_valid", 32'(dec_valid), 32'd1);
        chk("f_dec_pc", dec_pc, 32'h0);
        chk("f_dec_inst", dec_inst, 32'hFFFF_FFFF);
        dec_ready = 1'b1;
        ticks(8);
        chk("f_pop0", pops[0], 32'h0);
        chk("f_pop1", pops[1], 32'h4);
        chk("f_pop2", pops[2], 32'h8);
        chk("f_pop3", pops[3], 32'hC);
        chk("f_fire4", fires[4], 32'h10);
        chk("f_pop4", pops[4], 32'h10);

        // Latency 3, redirect with three in flight: all three are discarded
        do_reset();
        lat = 3; dec_ready = 1'b1;
        ticks(4);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        ticks(10);
        stale = 0;
        foreach (pops[i]) if (pops[i] < 32'h100) stale++;
        chk("d_stale", 32'(stale), 32'd0);
        chk("d_fire3", fires[3], 32'h100);
        chk("d_first_dec", 32'(first_dec_cyc), 32'd9);
        chk("d_pop0", pops[0], 32'h100);
        chk("d_pop1", pops[1], 32'h104);
        chk("d_pop2", pops[2], 32'h108);
`ifdef PREFETCH_STATS_EN
        chk("d_stat_drop", 32'(stat_drop_cnt), 32'd3);
`endif

        // Redirect coinciding with a response and a would-be request
        do_reset();
        lat = 1; dec_ready = 1'b1;
        ticks(4);
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        chk("c_req_blocked", 32'(req_v_seen), 32'd0);
        redirect_valid = 1'b0;
        ticks(6);
        chk("c_fire3", fires[3], 32'h200);
        chk("c_pop0", pops[0], 32'h0);
        chk("c_pop1", pops[1], 32'h200);
        chk("c_pop2", pops[2], 32'h204);

        // Memory back-pressure: address held, no skip or duplicate
        do_reset();
        lat = 1; dec_ready = 1'b1;
        ticks(3);
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_hold_addr", imem_req_addr, 32'h8);
            chk("b_hold_valid", 32'(req_v_seen), 32'd1);
        end
        mem_ready = 1'b1;
        ticks(6);
        chk("b_fire2", fires[2], 32'h8);
        chk("b_fire3", fires[3], 32'hC);
        chk("b_fire4", fires[4], 32'h10);
        chk("b_pop2", pops[2], 32'h8);
        chk("b_pop3", pops[3], 32'hC);

        // PC wraps modulo 2^32
        do_reset();
        lat = 1; dec_ready = 1'b1;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        ticks(7);
        chk("w_fire2", fires[2], 32'h0);
        chk("w_pop0", pops[0], 32'hFFFF_FFF8);
        chk("w_pop1", pops[1], 32'hFFFF_FFFC);
        chk("w_pop2", pops[2], 32'h0);

        // Asynchronous reset with a full FIFO
        do_reset();
        lat = 1; dec_ready = 1'b0;
        ticks(10);
        chk("r_full_valid", 32'(dec_valid), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("r_async_valid", 32'(dec_valid), 32'd0);
        chk("r_async_pc", dec_pc, 32'h0);
        chk("r_async_req", 32'(imem_req_valid), 32'd0);
        do_reset();
        lat = 1; dec_ready = 1'b1;
        ticks(3);
        chk("r_first_fire", 32'(first_fire_cyc), 32'd1);
        chk("r_fire0", fires[0], 32'h0);

        chk("inst_match", 32'(inst_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
